// File: rtl/fifo_ptr_pkg.sv
// Shared FIFO pointer helpers: address-width bounds, depth derivation and
// binary-to-Gray conversion used by both pointer domains.
package fifo_ptr_pkg;

  localparam int ADDR_W_MIN = 2;
  localparam int ADDR_W_MAX = 12;
  // Widest pointer any legal instance carries (address plus wrap bit).
  localparam int PTR_W_MAX  = ADDR_W_MAX + 1;

  // FIFO depth for a given memory address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Binary to Gray over the low w bits; bits above w are returned as zero.
  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin,
                                                    input int w);
    logic [PTR_W_MAX-1:0] mask;
    mask = (PTR_W_MAX'(1) << w) - PTR_W_MAX'(1);
    return (bin ^ (bin >> 1)) & mask;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// gray2bin: combinational prefix-XOR Gray-to-binary converter, shared by the
// write-side level estimate and the read-side pointer logic.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer, registered full flag and sticky
// overflow for the asynchronous FIFO. Defining WPTR_LEVEL_EN adds a
// pessimistic fill-level estimate (wlevel) and an almost_full flag.
module wptr_full_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AFULL_GAP = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              w_en,
  input  logic [ADDR_W:0]   rptr_gray_sync,
  input  logic              ovf_clr,
  output logic              w_inc,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
`ifdef WPTR_LEVEL_EN
  output logic [ADDR_W:0]   wlevel,
  output logic              almost_full,
`endif
  output logic              overflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = depth_of(ADDR_W);

  if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
    $error("wptr_full_ctrl: ADDR_W out of range");
  end
  if (AFULL_GAP < 1 || AFULL_GAP > DEPTH - 1) begin : g_bad_gap
    $error("wptr_full_ctrl: AFULL_GAP out of range");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  // Next pointer, its Gray form, full compare and overflow set/clear.
  always_comb begin
    w_inc   = w_en & ~full_q;
    wbin_d  = wbin_q + PW'(w_inc);
    wgray_d = PW'(bin2gray(PTR_W_MAX'(wbin_d), PW));
    // Full: write pointer one lap ahead of read, which in Gray means the
    // top two bits differ and the rest match.
    full_d  = (wgray_d == {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]});
    ovf_d   = ovf_q;
    if (ovf_clr)          ovf_d = 1'b0;
    if (w_en && full_q)   ovf_d = 1'b1;
  end

  // Pointer, Gray and flag registers; async reset clears everything.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr     = wbin_q[ADDR_W-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign overflow  = ovf_q;

`ifdef WPTR_LEVEL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AFULL_GAP);

  logic [PW-1:0] rbin;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          afull_q, afull_d;

  gray2bin #(.W(PW)) u_rptr_g2b (
    .gray_i (rptr_gray_sync),
    .bin_o  (rbin)
  );

  // Occupancy against the lagging read pointer: never under-reports.
  always_comb begin
    wlevel_d = wbin_d - rbin;
    afull_d  = (wlevel_d >= AF_THRESH);
  end

  // Level and almost-full registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      afull_q  <= 1'b0;
    end else begin
      wlevel_q <= wlevel_d;
      afull_q  <= afull_d;
    end
  end

  assign wlevel      = wlevel_q;
  assign almost_full = afull_q;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Testbench for wptr_full_ctrl (ADDR_W=4, AFULL_GAP=2). Level checks are
// compiled in when WPTR_LEVEL_EN is defined.
module tb_wptr_full_ctrl;

  localparam int AW   = 4;
  localparam int D    = 16;
  localparam int PW   = AW + 1;
  localparam int PMOD = 32;
  localparam int GAP  = 2;

  logic          wclk   = 1'b0;
  logic          wrst_n = 1'b0;
  logic          w_en   = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [PW-1:0] r_bin  = '0;
  logic [PW-1:0] rptr_gray_sync;
  logic          w_inc;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic          overflow;
`ifdef WPTR_LEVEL_EN
  logic [PW-1:0] wlevel;
  logic          almost_full;
`endif

  assign rptr_gray_sync = r_bin ^ (r_bin >> 1);

  wptr_full_ctrl #(.ADDR_W(AW), .AFULL_GAP(GAP)) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .w_en           (w_en),
    .rptr_gray_sync (rptr_gray_sync),
    .ovf_clr        (ovf_clr),
    .w_inc          (w_inc),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .full           (full),
`ifdef WPTR_LEVEL_EN
    .wlevel         (wlevel),
    .almost_full    (almost_full),
`endif
    .overflow       (overflow)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Reference model: write count modulo 2*DEPTH and occupancy arithmetic.
  int m_wbin;
  bit m_full;
  bit m_ovf;
  int m_lvl;
  bit m_af;

  function automatic void model_reset();
    m_wbin = 0; m_full = 0; m_ovf = 0; m_lvl = 0; m_af = 0;
  endfunction

  function automatic void model_step();
    int occ;
    bit was_full;
    was_full = m_full;
    if (w_en && !m_full) m_wbin = (m_wbin + 1) % PMOD;
    occ    = (m_wbin - int'(r_bin) + PMOD) % PMOD;
    m_full = (occ == D);
    if (w_en && was_full) m_ovf = 1;
    else if (ovf_clr)     m_ovf = 0;
    m_lvl = occ;
    m_af  = (occ >= D - GAP);
  endfunction

  function automatic int model_gray();
    return (m_wbin ^ (m_wbin >> 1));
  endfunction

  task automatic cycle();
    @(posedge wclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    w_en = 0; ovf_clr = 0; r_bin = '0;
    wrst_n = 0;
    model_reset();
    #2;
    wrst_n = 1;
  endtask

  task automatic test_reset();
    w_en = 1;
    #2;
    checks++; if (waddr !== '0) begin errors++; $display("FAIL rst0_waddr got %0d exp 0", waddr); end
    checks++; if (wptr_gray !== '0) begin errors++; $display("FAIL rst0_gray got %b exp 00000", wptr_gray); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst0_flags got full=%b ovf=%b exp 0 0", full, overflow); end
    checks++; if (w_inc !== 1'b1) begin errors++; $display("FAIL rst0_winc got %b exp 1", w_inc); end
`ifdef WPTR_LEVEL_EN
    checks++; if (wlevel !== '0 || almost_full !== 1'b0) begin errors++; $display("FAIL rst0_level got %0d/%b exp 0/0", wlevel, almost_full); end
`endif
    @(negedge wclk);
    wrst_n = 1;
    model_reset();
    repeat (5) cycle();
    checks++; if (waddr !== AW'(5)) begin errors++; $display("FAIL pre_rst_waddr got %0d exp 5", waddr); end
    // Mid-cycle asynchronous reset, well away from any clock edge.
    #2;
    wrst_n = 0;
    model_reset();
    #1;
    checks++; if (waddr !== '0 || wptr_gray !== '0) begin errors++; $display("FAIL async_rst_ptr got waddr=%0d gray=%b exp 0", waddr, wptr_gray); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b%b exp 00", full, overflow); end
    @(negedge wclk);
    wrst_n = 1;
    w_en = 0;
  endtask

  task automatic test_fill();
    do_reset();
    w_en = 1;
    for (int i = 0; i < D; i++) begin
      cycle();
      checks++; if (full !== (i == D - 1)) begin errors++; $display("FAIL fill_full write %0d got %b exp %b", i + 1, full, (i == D - 1)); end
      checks++; if (waddr !== AW'((i + 1) % D)) begin errors++; $display("FAIL fill_waddr write %0d got %0d exp %0d", i + 1, waddr, (i + 1) % D); end
    end
    checks++; if (wptr_gray !== 5'b11000) begin errors++; $display("FAIL fill_gray got %b exp 11000", wptr_gray); end
  endtask

  task automatic test_overflow();
    w_en = 1;
    #1;
    checks++; if (w_inc !== 1'b0) begin errors++; $display("FAIL ovf_winc got %b exp 0", w_inc); end
    cycle();
    checks++; if (waddr !== '0 || wptr_gray !== 5'b11000) begin errors++; $display("FAIL ovf_hold got waddr=%0d gray=%b exp 0 11000", waddr, wptr_gray); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    w_en = 0;
    repeat (3) cycle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    w_en = 1; ovf_clr = 1;
    cycle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
    w_en = 0;
    cycle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    ovf_clr = 0;
  endtask

  task automatic test_drain();
    r_bin = 5'd1;
    w_en  = 0;
    cycle();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %b exp 0", full); end
    w_en = 1;
    cycle();
    checks++; if (full !== 1'b1 || waddr !== AW'(1)) begin errors++; $display("FAIL refill got full=%b waddr=%0d exp 1 1", full, waddr); end
    w_en = 0;
  endtask

  task automatic test_wrap();
    bit saw_wrap;
    logic [PW-1:0] prev_gray;
    saw_wrap = 0;
    do_reset();
    w_en = 1;
    for (int i = 0; i < 40; i++) begin
      prev_gray = wptr_gray;
      cycle();
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full write %0d got %b exp 0", i + 1, full); end
      checks++; if (wptr_gray !== PW'(model_gray())) begin errors++; $display("FAIL wrap_gray write %0d got %b exp %b", i + 1, wptr_gray, PW'(model_gray())); end
      if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) saw_wrap = 1;
      r_bin = (i + 1 >= 3) ? PW'((i + 1 - 3) % PMOD) : '0;
    end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_seen got 0 exp 1"); end
    checks++; if (waddr !== AW'(40 % D)) begin errors++; $display("FAIL wrap_waddr got %0d exp %0d", waddr, 40 % D); end
    w_en = 0;
  endtask

`ifdef WPTR_LEVEL_EN
  task automatic test_level();
    do_reset();
    w_en = 1;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (i == 13) begin
        checks++; if (almost_full !== 1'b0 || wlevel !== PW'(13)) begin errors++; $display("FAIL level13 got %0d/%b exp 13/0", wlevel, almost_full); end
      end
    end
    checks++; if (almost_full !== 1'b1 || wlevel !== PW'(14)) begin errors++; $display("FAIL level14 got %0d/%b exp 14/1", wlevel, almost_full); end
    w_en = 0;
  endtask
`endif

  task automatic test_random();
    int occ;
    bit rd_fast;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rd_fast = ((c / 100) % 2) == 1;
      w_en    = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 7) == 0);
      occ = (m_wbin - int'(r_bin) + PMOD) % PMOD;
      if (occ > 0 && $urandom_range(0, rd_fast ? 1 : 5) == 0) r_bin = r_bin + 1'b1;
      #1;
      checks++; if (w_inc !== (w_en && !m_full)) begin errors++; $display("FAIL rnd_winc cyc %0d got %b exp %b", c, w_inc, (w_en && !m_full)); end
      cycle();
      checks++; if (waddr !== AW'(m_wbin % D)) begin errors++; $display("FAIL rnd_waddr cyc %0d got %0d exp %0d", c, waddr, m_wbin % D); end
      checks++; if (wptr_gray !== PW'(model_gray())) begin errors++; $display("FAIL rnd_gray cyc %0d got %b exp %b", c, wptr_gray, PW'(model_gray())); end
      checks++; if (full !== m_full) begin errors++; $display("FAIL rnd_full cyc %0d got %b exp %b", c, full, m_full); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", c, overflow, m_ovf); end
`ifdef WPTR_LEVEL_EN
      checks++; if (wlevel !== PW'(m_lvl) || almost_full !== m_af) begin errors++; $display("FAIL rnd_level cyc %0d got %0d/%b exp %0d/%b", c, wlevel, almost_full, m_lvl, m_af); end
`endif
    end
    w_en = 0; ovf_clr = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
`ifdef WPTR_LEVEL_EN
    test_level();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Parametrised write-side pointer and full-flag controller for the asynchronous FIFO, in the `wclk` domain. It keeps a binary and Gray write pointer of configurable depth, a registered (glitch-free) `full` flag, and a sticky overflow error. Optionally it also produces a fill-level estimate and an almost-full flag. It feeds the FIFO memory write address and exports the Gray pointer to the read-domain synchroniser.

## Interface
- `ADDR_W`, 4: memory address width; depth `DEPTH = 2**ADDR_W`; legal range 2..12.
- `AFULL_GAP`, 2: almost-full asserts when free slots ≤ `AFULL_GAP`; legal range 1..`DEPTH-1`.

Ports:
- `wclk`  in  1  write clock.
- `wrst_n`  in  1  asynchronous reset, active-low.
- `w_en`  in  1  write request.
- `rptr_gray_sync`  in  `ADDR_W+1`  read Gray pointer, already two-flop synchronised into `wclk`.
- `ovf_clr`  in  1  clears `overflow`.
- `w_inc`  out  1  combinational accepted-write strobe, `w_en & ~full`.
- `waddr`  out  `ADDR_W`  memory write address, `wptr_bin[ADDR_W-1:0]`.
- `wptr_gray`  out  `ADDR_W+1`  registered Gray write pointer.
- `full`  out  1  registered full flag.
- `overflow`  out  1  sticky: a write was attempted while full.
- `wlevel`  out  `ADDR_W+1`  registered fill estimate. Present only with the macro.
- `almost_full`  out  1  registered. Present only with the macro.

## Operation
- `wptr_bin` is `ADDR_W+1` bits. `wbin_next = wptr_bin + w_inc`, modulo `2**(ADDR_W+1)`.
- `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Each cycle: `wptr_bin <= wbin_next` and `wptr_gray <= wgray_next`. The Gray output is always a register; no combinational Gray output.
- `full_next` is true when `wgray_next` equals `rptr_gray_sync` with its two MSBs inverted and the remaining bits equal. `full <= full_next`.
- `overflow` is set when `w_en & full`. It is cleared when `ovf_clr`. If both occur in the same cycle, set wins.
- Level (macro on):
  - `rbin = gray2bin(rptr_gray_sync)`.
  - `wlevel <= wbin_next - rbin`, `ADDR_W+1` bits, range 0..`DEPTH`.
  - `almost_full <= (wbin_next - rbin) >= DEPTH - AFULL_GAP`.
- The estimate is pessimistic because the synchronised read pointer lags. It never under-reports occupancy.
- Reset mid-operation clears all state asynchronously. The read domain must be reset in the same event.
- `rptr_gray_sync` is trusted to change by at most one Gray step per sample. The block does no checking of it.

## Timing
- Reset values: `wptr_bin`, `wptr_gray`, `waddr`, `full`, `overflow`, `wlevel`, `almost_full` are all 0. `w_inc` equals `w_en`.
- Write accepted at edge N: `waddr` advances and `wptr_gray` updates at N. `full` reflects the post-write state at N, with zero extra cycles of latency.
- `full` deassertion: 1 `wclk` cycle after `rptr_gray_sync` changes, plus the external 2-flop synchroniser delay.
- Wrap-around: `wptr_bin` wraps 2·`DEPTH`-1 → 0. `waddr` wraps `DEPTH`-1 → 0. The MSB toggle distinguishes full from empty.
- `overflow` asserts the cycle after the rejected write.

## Configuration
- `WPTR_LEVEL_EN` defined:
  - `wlevel` and `almost_full` ports exist.
  - The `gray2bin` instance and subtractor are built.
- `WPTR_LEVEL_EN` not defined:
  - Those ports, the instance and the subtractor are absent.
  - All other behaviour is bit-identical.

## Structure
- Package `fifo_ptr_pkg` holds:
  - function `bin2gray`, parametrised on width;
  - `ADDR_W` legality bounds;
  - the `DEPTH` derivation.
- Sub-module `gray2bin` (parameter `W`): a combinational prefix-XOR converter. The read-side successor reuses it.

## Test plan
Defaults: `ADDR_W=4`, `AFULL_GAP=2`, depth 16.

1. Reset: assert `wrst_n`=0 mid-stream → all outputs 0 immediately (asynchronously), independent of `wclk`.
2. Fill: 16 consecutive writes, `rptr_gray_sync`=0 → `full`=1 at the 16th edge, `wptr_gray`=5'b11000, `waddr`=0.
3. Overflow: `w_en`=1 while full → `w_inc`=0, pointer holds, `overflow`=1 next cycle. It stays set until `ovf_clr`. With `ovf_clr` and a new violation in the same cycle, `overflow` stays 1.
4. Drain: with full, set `rptr_gray_sync`=5'b00001 → `full`=0 next cycle; the next write is accepted and `full` returns to 1.
5. Wrap: 40 writes with the read pointer tracking 3 behind → `wptr_bin` passes 31→0, `wptr_gray` goes 10000→00000, `full` is never asserted.
6. Level (macro on): 14 writes, `rptr_gray_sync`=0 → `wlevel`=14 and `almost_full`=1 at the 14th edge. After 13 writes, `almost_full`=0.
